seq_gen_2b_tx: RTL

- Transmitter for the two-bit-per-clock serial pattern interface {A,B} used by the 01110 detector.
- Accepts a SEQ_WIDTH-bit pattern word through a valid/ready load port.
- Drives the word out MSB-first, one pair per clock: A = higher bit, B = lower bit.
- Serial stream order is D[W-1], D[W-2], ..., D[0], i.e. A,B,A,B,...
- Drives the detector's A/B inputs directly in system and bench use; replaces hand-written stimulus loops.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_match_cnt.sv | 50 +++++
 rtl/seq_gen_2b_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the two-bit serial pattern transmitter and the
// 01110 detector that consumes its {A,B} stream.
//   seq_state_t  : transmitter state encodings IDLE / SEND / DONE
//   PATTERN      : the detected sequence 01110, PATTERN_LEN bits long
//   DEMO_PATTERN : 24-bit demonstration word containing five occurrences
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int unsigned PATTERN_LEN  = 5;
    localparam logic [4:0]  PATTERN      = 5'b01110;
    localparam logic [23:0] DEMO_PATTERN = 24'b011101110111001110001110;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating counter of 01110 occurrences in the transmitted bit stream.
// Built only when SEQ_GEN_MATCH_CNT_EN is defined.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous active-high reset
//   clear : start of a new pattern (history and count cleared)
//   en    : a pair {a,b} is consumed this cycle
//   a, b  : current pair, a transmitted before b
//   cnt   : saturating match count
`ifdef SEQ_GEN_MATCH_CNT_EN
module seq_match_cnt
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] cnt
);

    // hist[0] is the most recently transmitted bit
    logic [3:0]       hist_q;
    logic [4:0]       win_a;
    logic [4:0]       win_b;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    always_comb begin
        win_a = {hist_q, a};
        win_b = {hist_q[2:0], a, b};
        inc   = 2'(win_a == PATTERN) + 2'(win_b == PATTERN);
        sum   = {1'b0, cnt} + (CNT_W+1)'(inc);
    end

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            hist_q <= '0;
            cnt    <= '0;
        end else if (en) begin
            hist_q <= {hist_q[1:0], a, b};
            cnt    <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/seq_gen_2b_tx.sv
// Two-bit-per-clock serial pattern transmitter.
// A SEQ_WIDTH-bit word accepted on the load port is driven MSB-first as
// pairs {A,B} (A = higher bit), one pair per clock, followed by a
// one-cycle done pulse.
// Optional feature: define SEQ_GEN_MATCH_CNT_EN to count 01110 occurrences
// in the transmitted stream on match_cnt; otherwise match_cnt is 0.
// Ports:
//   clk, clr          : clock and synchronous active-high reset
//   load_valid/ready  : load handshake; load_ready = (state == IDLE)
//   load_data         : pattern word, bit SEQ_WIDTH-1 sent first
//   hold              : freezes transmission in SEND
//   A, B, out_valid   : current pair and its qualifier (registered)
//   done              : one-cycle pulse after the last pair
//   match_cnt         : saturating 01110 count
module seq_gen_2b_tx
    import seq_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = 24,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [SEQ_WIDTH-1:0] load_data,
    input  logic                 hold,
    output logic                 A,
    output logic                 B,
    output logic                 out_valid,
    output logic                 done,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int unsigned N  = SEQ_WIDTH / 2;
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

    generate
        if ((SEQ_WIDTH % 2) != 0 || SEQ_WIDTH < 4) begin : g_bad_width
            $error("seq_gen_2b_tx: SEQ_WIDTH must be even and >= 4");
        end
    endgenerate

    seq_state_t           state_q, state_d;
    logic [SEQ_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 a_d, b_d, ov_d, done_d;

    assign load_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            beat_q    <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            beat_q    <= beat_d;
            A         <= a_d;
            B         <= b_d;
            out_valid <= ov_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        a_d     = A;
        b_d     = B;
        ov_d    = out_valid;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                a_d  = 1'b0;
                b_d  = 1'b0;
                ov_d = 1'b0;
                if (load_valid) begin
                    // first pair goes straight to the outputs; the shift
                    // register keeps only the remaining pairs
                    state_d = SEND;
                    a_d     = load_data[SEQ_WIDTH-1];
                    b_d     = load_data[SEQ_WIDTH-2];
                    shreg_d = load_data << 2;
                    beat_d  = '0;
                    ov_d    = 1'b1;
                end
            end
            SEND: begin
                if (!hold) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        ov_d    = 1'b0;
                        done_d  = 1'b1;
                        shreg_d = '0;
                        beat_d  = '0;
                    end else begin
                        a_d     = shreg_q[SEQ_WIDTH-1];
                        b_d     = shreg_q[SEQ_WIDTH-2];
                        shreg_d = shreg_q << 2;
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                ov_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                beat_d  = '0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                ov_d    = 1'b0;
            end
        endcase
    end

`ifdef SEQ_GEN_MATCH_CNT_EN
    logic cnt_clear;
    logic cnt_en;

    // the registered pair on A/B is the one consumed at a non-held SEND edge
    assign cnt_clear = (state_q == IDLE) && load_valid;
    assign cnt_en    = (state_q == SEND) && !hold;

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .clr   (clr),
        .clear (cnt_clear),
        .en    (cnt_en),
        .a     (A),
        .b     (B),
        .cnt   (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule
